alu_exec_unit: RTL

- Execute-stage consumer of the ALU decoder outputs (ALUControl, FlagW).
- Accepts one decoded operation per handshake and evaluates its ARM condition field against the architectural NZCV flag register.
- Computes a 2-operand ALU result and registers it. Conditionally updates NZCV per FlagW.
- Sits between decode and writeback; valid/ready on both sides; one output register stage.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_exec_unit_cond_check.sv | 40 ++++
 rtl/alu_exec_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: operation codes, ARM condition
// codes, NZCV flag bit positions and the output-register state type.
package alu_pkg;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } pipe_state_e;

endpackage

// File: rtl/alu_exec_unit_cond_check.sv
// Combinational ARM condition-code evaluator against an NZCV flag vector;
// shared between the execute unit and the branch logic.
module cond_check
   import alu_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       pass
);

   logic w_n, w_z, w_c, w_v;

   assign w_n = flags[FLAG_N];
   assign w_z = flags[FLAG_Z];
   assign w_c = flags[FLAG_C];
   assign w_v = flags[FLAG_V];

   always_comb begin
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = w_z;
         COND_NE: pass = !w_z;
         COND_CS: pass = w_c;
         COND_CC: pass = !w_c;
         COND_MI: pass = w_n;
         COND_PL: pass = !w_n;
         COND_VS: pass = w_v;
         COND_VC: pass = !w_v;
         COND_HI: pass = w_c && !w_z;
         COND_LS: pass = !w_c || w_z;
         COND_GE: pass = (w_n == w_v);
         COND_LT: pass = (w_n != w_v);
         COND_GT: pass = !w_z && (w_n == w_v);
         COND_LE: pass = w_z || (w_n != w_v);
         COND_AL: pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: conditional 2-operand ALU with NZCV flag register and a
// single valid/ready output register allowing full-throughput streaming.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       alu_control,
   input  logic [1:0]       flag_w,
   input  logic [3:0]       cond,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_exec,
   output logic [3:0]       flags
);

   pipe_state_e      r_state;
   pipe_state_e      w_state_nxt;
   logic             w_accept;
   logic             w_pass;
   logic [WIDTH-1:0] w_b;
   logic             w_cin;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_result;
   logic             w_c, w_v;
   logic [3:0]       w_flags_nxt;
   logic [3:0]       r_flags;
   logic [WIDTH-1:0] r_result;
   logic             r_exec;

   // Condition is judged against the flags as they stand before this edge,
   // so a flag-setting op followed immediately by a dependent op needs no bubble.
   cond_check u_cond_check (
      .cond  (cond),
      .flags (r_flags),
      .pass  (w_pass)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_EMPTY;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      in_ready    = (r_state == ST_EMPTY) || out_ready;
      w_accept    = in_valid && in_ready;
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
         ST_FULL:  if (out_ready && !w_accept) w_state_nxt = ST_EMPTY;
         default:  w_state_nxt = ST_EMPTY;
      endcase
   end

   always_comb begin
      w_b      = (alu_control == ALU_SUB) ? ~src_b : src_b;
      w_cin    = (alu_control == ALU_SUB);
      w_sum    = {1'b0, src_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};
      w_result = w_sum[WIDTH-1:0];
      w_c      = w_sum[WIDTH];
      w_v      = (src_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != src_a[WIDTH-1]);
      case (alu_control)
         ALU_AND: begin
            w_result = src_a & src_b;
            w_c      = 1'b0;
            w_v      = 1'b0;
         end
         ALU_ORR: begin
            w_result = src_a | src_b;
            w_c      = 1'b0;
            w_v      = 1'b0;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_flags_nxt = r_flags;
      if (w_accept && w_pass) begin
         if (flag_w[1]) begin
            w_flags_nxt[FLAG_N] = w_result[WIDTH-1];
            w_flags_nxt[FLAG_Z] = (w_result == '0);
         end
         if (flag_w[0]) begin
            w_flags_nxt[FLAG_C] = w_c;
            w_flags_nxt[FLAG_V] = w_v;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flags  <= '0;
         r_result <= '0;
         r_exec   <= 1'b0;
      end else begin
         r_flags <= w_flags_nxt;
         if (w_accept) begin
            r_result <= w_result;
            r_exec   <= w_pass;
         end
      end
   end

   assign out_valid  = (r_state == ST_FULL);
   assign out_result = r_result;
   assign out_exec   = r_exec;
   assign flags      = r_flags;

endmodule
